// File: rtl/simple_cache_pkg.sv
// Shared types and sizes for the simple_cache block: address fields, array
// depths, check-bit widths and the miss-handling FSM state encoding.
package simple_cache_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 13;
    localparam int INDEX_W   = 9;
    localparam int TAG_W     = WORD_W - INDEX_W;
    localparam int LINES     = 512;
    localparam int MEM_DEPTH = 8192;
    localparam int HAM_W     = 6;
    localparam int CHK_W     = HAM_W + 1;
    localparam int CODE_W    = DATA_W + HAM_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Hamming check bits sit at power-of-two code positions.
    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

endpackage

// File: rtl/simple_cache_secded.sv
// SECDED codec: Hamming(38,32) plus an overall even-parity bit (check bit 6).
// Encoder and decoder are independent paths so one instance serves both.
module secded_codec
    import simple_cache_pkg::*;
(
    input  logic [DATA_W-1:0] enc_data_i,
    output logic [CHK_W-1:0]  enc_chk_o,
    input  logic [DATA_W-1:0] dec_data_i,
    input  logic [CHK_W-1:0]  dec_chk_i,
    output logic [DATA_W-1:0] dec_data_o,
    output logic              single_err_o,
    output logic              double_err_o
);

    function automatic logic [CODE_W:1] spread(input logic [DATA_W-1:0] d);
        logic [CODE_W:1] cw;
        int j;
        cw = '0;
        j  = 0;
        for (int p = 1; p <= CODE_W; p++) begin
            if (!is_pow2(p)) begin
                cw[p] = d[j];
                j++;
            end
        end
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] gather(input logic [CODE_W:1] cw);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int p = 1; p <= CODE_W; p++) begin
            if (!is_pow2(p)) begin
                d[j] = cw[p];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [HAM_W-1:0] hamming(input logic [CODE_W:1] cw);
        logic [HAM_W-1:0] s;
        s = '0;
        for (int p = 1; p <= CODE_W; p++) begin
            for (int k = 0; k < HAM_W; k++) begin
                if (((p >> k) & 1) != 0) begin
                    s[k] = s[k] ^ cw[p];
                end
            end
        end
        return s;
    endfunction

    logic [CODE_W:1] enc_cw;
    logic [HAM_W-1:0] enc_ham;
    logic [CODE_W:1] dec_cw;
    logic [HAM_W-1:0] syn;
    logic            overall;

    always_comb begin
        enc_cw    = spread(enc_data_i);
        enc_ham   = hamming(enc_cw);
        enc_chk_o = {^{enc_data_i, enc_ham}, enc_ham};
    end

    // Odd overall parity means one flipped bit (syndrome 0 => the parity bit
    // itself); even parity with a non-zero syndrome means two flipped bits.
    always_comb begin
        dec_cw = spread(dec_data_i);
        for (int k = 0; k < HAM_W; k++) begin
            dec_cw[1 << k] = dec_chk_i[k];
        end
        syn          = hamming(dec_cw);
        overall      = ^{dec_cw, dec_chk_i[CHK_W-1]};
        single_err_o = 1'b0;
        double_err_o = 1'b0;
        if (overall) begin
            if (int'(syn) > CODE_W) begin
                double_err_o = 1'b1;
            end else begin
                single_err_o = 1'b1;
                if (syn != '0) begin
                    dec_cw[syn] = ~dec_cw[syn];
                end
            end
        end else if (syn != '0) begin
            double_err_o = 1'b1;
        end
        dec_data_o = gather(dec_cw);
    end

endmodule

// File: rtl/simple_cache.sv
// Direct-mapped, write-through/write-allocate cache over an 8192x32 dual-port
// memory. Define SIMPLE_CACHE_ECC_EN to protect lines with SECDED check bits.
module simple_cache
    import simple_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_read_en,
    input  logic              CPU_write_en,
    input  logic [ADDR_W-1:0] CPU_addr,
    input  logic [DATA_W-1:0] CPU_write_din,
    output logic [DATA_W-1:0] CPU_read_dout,
    output logic              isCacheStall,
    input  logic              mem_b_we,
    input  logic [WORD_W-1:0] mem_b_addr,
    input  logic [DATA_W-1:0] mem_b_din,
    output logic [DATA_W-1:0] mem_b_dout,
    input  logic              error_dwe,
    input  logic              error_pwe,
    input  logic [DATA_W-1:0] error_din,
    input  logic [CHK_W-1:0]  error_pin,
    input  logic [INDEX_W-1:0] error_addr,
    output logic [CHK_W-1:0]  parity_bits,
    output logic [CHK_W-1:0]  cache_parity_dout,
    output state_t            dbg_state_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] mem_a_dout_q;
    logic [DATA_W-1:0] mem_b_dout_q;
    logic [DATA_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [LINES-1:0]  valid_q;
    state_t            state_q;
    logic [WORD_W-1:0] fill_word_q;

    logic [WORD_W-1:0]  cpu_word;
    logic [INDEX_W-1:0] cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic [DATA_W-1:0]  line_data;
    logic               tag_match;
    logic [DATA_W-1:0]  hit_data;
    logic               hit;
    logic               scrub;
    logic               load_req;
    logic               store_en;
    logic               miss;
    logic               fill_en;

    logic               line_wr_en;
    logic [INDEX_W-1:0] line_wr_idx;
    logic [TAG_W-1:0]   line_wr_tag;
    logic [DATA_W-1:0]  line_wr_data;

    logic [INDEX_W-1:0] b_idx;
    logic [TAG_W-1:0]   b_tag;
    logic               b_store_same;
    logic               b_inval;
    logic               unused_addr_bits;

    assign cpu_word  = CPU_addr[14:2];
    assign cpu_idx   = cpu_word[INDEX_W-1:0];
    assign cpu_tag   = cpu_word[WORD_W-1:INDEX_W];
    assign line_data = data_q[cpu_idx];
    assign tag_match = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign unused_addr_bits = ^{CPU_addr[31:15], CPU_addr[1:0]};

`ifdef SIMPLE_CACHE_ECC_EN
    logic [CHK_W-1:0]  chk_q [LINES];
    logic [CHK_W-1:0]  wr_chk;
    logic [DATA_W-1:0] fixed_data;
    logic              single_err;
    logic              double_err;

    secded_codec u_codec (
        .enc_data_i   (line_wr_data),
        .enc_chk_o    (wr_chk),
        .dec_data_i   (line_data),
        .dec_chk_i    (chk_q[cpu_idx]),
        .dec_data_o   (fixed_data),
        .single_err_o (single_err),
        .double_err_o (double_err)
    );

    // An uncorrectable line is simply not a hit, so the normal miss path refetches it.
    assign hit_data          = fixed_data;
    assign hit               = tag_match && !double_err;
    assign scrub             = load_req && hit && single_err;
    assign parity_bits       = wr_chk;
    assign cache_parity_dout = chk_q[error_addr];

    always_ff @(posedge clk) begin
        if (line_wr_en) begin
            chk_q[line_wr_idx] <= wr_chk;
        end
        if (error_pwe) begin
            chk_q[error_addr] <= error_pin;
        end
    end
`else
    logic unused_ecc_port;

    assign hit_data          = line_data;
    assign hit               = tag_match;
    assign scrub             = 1'b0;
    assign parity_bits       = '0;
    assign cache_parity_dout = '0;
    assign unused_ecc_port   = ^{error_pwe, error_pin};
`endif

    assign load_req = CPU_read_en && !CPU_write_en && (state_q == IDLE);
    assign store_en = CPU_write_en && (state_q == IDLE);
    assign miss     = load_req && !hit;
    assign fill_en  = (state_q == FILL);

    assign isCacheStall = rst && (fill_en || miss);
    assign mem_b_dout   = mem_b_dout_q;
    assign dbg_state_o  = state_q;

    always_comb begin
        CPU_read_dout = '0;
        if (store_en && CPU_read_en) begin
            CPU_read_dout = CPU_write_din;
        end else if (load_req && hit) begin
            CPU_read_dout = hit_data;
        end
    end

    always_comb begin
        line_wr_en   = 1'b0;
        line_wr_idx  = cpu_idx;
        line_wr_tag  = cpu_tag;
        line_wr_data = CPU_write_din;
        if (fill_en) begin
            line_wr_en   = 1'b1;
            line_wr_idx  = fill_word_q[INDEX_W-1:0];
            line_wr_tag  = fill_word_q[WORD_W-1:INDEX_W];
            line_wr_data = mem_a_dout_q;
        end else if (store_en) begin
            line_wr_en = 1'b1;
        end else if (scrub) begin
            line_wr_en   = 1'b1;
            line_wr_data = hit_data;
        end
    end

    // A user write drops the line it aliases, judged against the line contents
    // after this cycle's fill/store; a CPU store to the same word wins instead.
    assign b_idx        = mem_b_addr[INDEX_W-1:0];
    assign b_tag        = mem_b_addr[WORD_W-1:INDEX_W];
    assign b_store_same = store_en && (mem_b_addr == cpu_word);

    always_comb begin
        b_inval = 1'b0;
        if (mem_b_we) begin
            if (line_wr_en && (line_wr_idx == b_idx)) begin
                b_inval = (line_wr_tag == b_tag) && !b_store_same;
            end else begin
                b_inval = valid_q[b_idx] && (tag_q[b_idx] == b_tag);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fill_word_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        state_q     <= FILL;
                        fill_word_q <= cpu_word;
                    end
                end
                FILL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            if (line_wr_en) begin
                valid_q[line_wr_idx] <= 1'b1;
            end
            if (b_inval) begin
                valid_q[b_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_wr_en) begin
            data_q[line_wr_idx] <= line_wr_data;
            tag_q[line_wr_idx]  <= line_wr_tag;
        end
        if (error_dwe) begin
            data_q[error_addr] <= error_din;
        end
    end

    // Port A is written after port B so the CPU value lands on a same-word clash;
    // the port A read forwards a same-cycle user write so a fill never goes stale.
    always_ff @(posedge clk) begin
        if (mem_b_we) begin
            mem_q[mem_b_addr] <= mem_b_din;
        end
        if (store_en) begin
            mem_q[cpu_word] <= CPU_write_din;
        end
        mem_a_dout_q <= (mem_b_we && (mem_b_addr == cpu_word)) ? mem_b_din : mem_q[cpu_word];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_b_dout_q <= '0;
        end else begin
            mem_b_dout_q <= mem_q[mem_b_addr];
        end
    end

endmodule

// File: tb/tb_simple_cache.sv
// Directed bench for simple_cache: hits, misses, write-through, user-port
// invalidation, port priority, reset mid-fill and (with ECC) correction.
module tb_simple_cache;
    import simple_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        CPU_read_en;
    logic        CPU_write_en;
    logic [31:0] CPU_addr;
    logic [31:0] CPU_write_din;
    logic [31:0] CPU_read_dout;
    logic        isCacheStall;
    logic        mem_b_we;
    logic [12:0] mem_b_addr;
    logic [31:0] mem_b_din;
    logic [31:0] mem_b_dout;
    logic        error_dwe;
    logic        error_pwe;
    logic [31:0] error_din;
    logic [6:0]  error_pin;
    logic [8:0]  error_addr;
    logic [6:0]  parity_bits;
    logic [6:0]  cache_parity_dout;
    state_t      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    simple_cache dut (
        .clk               (clk),
        .rst               (rst),
        .CPU_read_en       (CPU_read_en),
        .CPU_write_en      (CPU_write_en),
        .CPU_addr          (CPU_addr),
        .CPU_write_din     (CPU_write_din),
        .CPU_read_dout     (CPU_read_dout),
        .isCacheStall      (isCacheStall),
        .mem_b_we          (mem_b_we),
        .mem_b_addr        (mem_b_addr),
        .mem_b_din         (mem_b_din),
        .mem_b_dout        (mem_b_dout),
        .error_dwe         (error_dwe),
        .error_pwe         (error_pwe),
        .error_din         (error_din),
        .error_pin         (error_pin),
        .error_addr        (error_addr),
        .parity_bits       (parity_bits),
        .cache_parity_dout (cache_parity_dout),
        .dbg_state_o       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        CPU_read_en  = 1'b0;
        CPU_write_en = 1'b0;
        mem_b_we     = 1'b0;
        error_dwe    = 1'b0;
        error_pwe    = 1'b0;
    endtask

    task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        drive_idle();
        CPU_write_en  = 1'b1;
        CPU_addr      = addr;
        CPU_write_din = data;
        #1;
        check("store_stall", 32'(isCacheStall), 32'd0);
    endtask

    task automatic cpu_load(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input int exp_stalls);
        int stalls;
        stalls = 0;
        @(negedge clk);
        drive_idle();
        CPU_read_en = 1'b1;
        CPU_addr    = addr;
        #1;
        while (isCacheStall && stalls < 8) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check({tag, "_data"}, CPU_read_dout, exp_data);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    endtask

    task automatic port_b_write(input logic [12:0] word, input logic [31:0] data);
        @(negedge clk);
        drive_idle();
        mem_b_we   = 1'b1;
        mem_b_addr = word;
        mem_b_din  = data;
    endtask

    task automatic port_b_read(input string tag, input logic [12:0] word, input logic [31:0] exp);
        @(negedge clk);
        drive_idle();
        mem_b_addr = word;
        @(negedge clk);
        #1;
        check(tag, mem_b_dout, exp);
    endtask

    task automatic inject_data(input logic [8:0] idx, input logic [31:0] val);
        @(negedge clk);
        drive_idle();
        error_dwe  = 1'b1;
        error_addr = idx;
        error_din  = val;
    endtask

    task automatic inject_chk(input logic [8:0] idx, input logic [6:0] val);
        @(negedge clk);
        drive_idle();
        error_pwe  = 1'b1;
        error_addr = idx;
        error_pin  = val;
    endtask

    task automatic check_parity(input string tag, input logic [8:0] idx, input logic [6:0] exp);
        @(negedge clk);
        drive_idle();
        error_addr = idx;
        #1;
        check(tag, 32'(cache_parity_dout), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive_idle();
        CPU_addr      = '0;
        CPU_write_din = '0;
        mem_b_addr    = '0;
        mem_b_din     = '0;
        error_din     = '0;
        error_pin     = '0;
        error_addr    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", 32'(isCacheStall), 32'd0);
        check("rst_mem_b_dout", mem_b_dout, 32'd0);
        check("rst_read_dout", CPU_read_dout, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b1;

        // Store then load hits with no stall; store reaches memory.
        cpu_store(32'h0000_0040, 32'hDEAD_BEEF);
        cpu_load("hit_0x40", 32'h0000_0040, 32'hDEAD_BEEF, 0);
        port_b_read("write_through", 13'h010, 32'hDEAD_BEEF);

        // User-port write then load: miss with two stall cycles, then hits.
        port_b_write(13'h100, 32'h1234_5678);
        cpu_load("miss_0x400", 32'h0000_0400, 32'h1234_5678, 2);
        cpu_load("rehit_0x400", 32'h0000_0400, 32'h1234_5678, 0);
        port_b_read("pb_read_0x100", 13'h100, 32'h1234_5678);

        // User write to a cached word invalidates the line.
        port_b_write(13'h010, 32'h0000_0001);
        cpu_load("inval_0x40", 32'h0000_0040, 32'h0000_0001, 2);

        // Simultaneous read and write returns the store data.
        @(negedge clk);
        drive_idle();
        CPU_read_en   = 1'b1;
        CPU_write_en  = 1'b1;
        CPU_addr      = 32'h0000_0080;
        CPU_write_din = 32'hCAFE_F00D;
        #1;
        check("rw_dout", CPU_read_dout, 32'hCAFE_F00D);
        check("rw_stall", 32'(isCacheStall), 32'd0);
        cpu_load("rw_hit", 32'h0000_0080, 32'hCAFE_F00D, 0);

        // Same-word writes on both ports: CPU value wins, line stays valid.
        @(negedge clk);
        drive_idle();
        CPU_write_en  = 1'b1;
        CPU_addr      = 32'h0000_0100;
        CPU_write_din = 32'hAAAA_5555;
        mem_b_we      = 1'b1;
        mem_b_addr    = 13'h040;
        mem_b_din     = 32'h5555_AAAA;
        port_b_read("port_a_wins", 13'h040, 32'hAAAA_5555);
        cpu_load("port_a_hit", 32'h0000_0100, 32'hAAAA_5555, 0);

        // Same index, different tag: write-allocate evicts, old address refetches.
        cpu_store(32'h0000_0840, 32'h0000_0055);
        cpu_load("alloc_0x840", 32'h0000_0840, 32'h0000_0055, 0);
        cpu_load("evict_0x40", 32'h0000_0040, 32'h0000_0001, 2);
        cpu_load("ignored_bits", 32'h8000_0043, 32'h0000_0001, 0);

        @(negedge clk);
        drive_idle();
        #1;
        check("idle_dout", CPU_read_dout, 32'd0);

        // Reset asserted during FILL abandons the fill.
        port_b_write(13'h300, 32'h0000_0077);
        @(negedge clk);
        drive_idle();
        CPU_read_en = 1'b1;
        CPU_addr    = 32'h0000_0C00;
        #1;
        check("mf_miss_stall", 32'(isCacheStall), 32'd1);
        @(negedge clk);
        #1;
        check("mf_fill_state", 32'(dbg_state), 32'(FILL));
        check("mf_fill_stall", 32'(isCacheStall), 32'd1);
        rst = 1'b0;
        #1;
        check("mf_rst_stall", 32'(isCacheStall), 32'd0);
        check("mf_rst_state", 32'(dbg_state), 32'(IDLE));
        check("mf_rst_mem_b_dout", mem_b_dout, 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        cpu_load("mf_reload", 32'h0000_0C00, 32'h0000_0077, 2);
        cpu_load("mf_cleared", 32'h0000_0400, 32'h1234_5678, 2);

`ifdef SIMPLE_CACHE_ECC_EN
        // 0x0000000F encodes to check bits 7'b1000111.
        @(negedge clk);
        drive_idle();
        CPU_write_en  = 1'b1;
        CPU_addr      = 32'h0000_0040;
        CPU_write_din = 32'h0000_000F;
        #1;
        check("enc_bits", 32'(parity_bits), 32'h47);
        check_parity("chk_stored", 9'h010, 7'h47);
        inject_chk(9'h010, 7'h46);
        cpu_load("chk_flip", 32'h0000_0040, 32'h0000_000F, 0);
        check_parity("chk_scrubbed", 9'h010, 7'h47);
        inject_data(9'h010, 32'h0000_000E);
        cpu_load("data_flip", 32'h0000_0040, 32'h0000_000F, 0);
        inject_chk(9'h010, 7'h45);
        cpu_load("data_scrubbed", 32'h0000_0040, 32'h0000_000F, 0);
        inject_data(9'h010, 32'h0000_000C);
        cpu_load("double_refetch", 32'h0000_0040, 32'h0000_000F, 2);
        check_parity("chk_refilled", 9'h010, 7'h47);
`else
        cpu_store(32'h0000_0040, 32'h0000_000F);
        inject_data(9'h010, 32'h0000_000E);
        cpu_load("raw_inject", 32'h0000_0040, 32'h0000_000E, 0);
        inject_chk(9'h010, 7'h7F);
        check_parity("no_ecc_parity", 9'h010, 7'h00);
        check("no_ecc_enc", 32'(parity_bits), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/simple_cache.md
SIMPLE_CACHE -- requirements
Module: simple_cache

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 CPU_read_en / CPU_write_en  in  1 each  CPU load / store request.
REQ-004 CPU_addr  in  32  byte address; word index = CPU_addr[14:2], bits [1:0] and [31:15] ignored.
REQ-005 CPU_write_din  in  32  store data; CPU_read_dout  out  32  load data (combinational).
REQ-006 isCacheStall  out  1  high while a load miss is being serviced.
REQ-007 mem_b_we  in  1,  mem_b_addr  in  13,  mem_b_din  in  32,  mem_b_dout  out  32: user port of backing memory.
REQ-008 error_dwe / error_pwe  in  1 each,  error_din  in  32,  error_pin  in  7,  error_addr  in  9: fault-injection port.
REQ-009 parity_bits  out  7  encoder output for data currently entering the cache; cache_parity_dout  out  7  stored check bits at error_addr.

Function
REQ-010 Backing memory SHALL be 8192x32 true dual-port: port A internal, port B user; synchronous read, 1-cycle latency.
REQ-011 Cache SHALL be direct-mapped, 512 one-word lines: index CPU_addr[10:2], tag CPU_addr[14:11], plus valid bit and 7 check bits.
REQ-012 Load hit (valid, tag match, no uncorrectable error): CPU_read_dout = line data same cycle, isCacheStall=0.
REQ-013 Load miss: FSM IDLE->FILL; miss cycle stalls and presents address on port A; FILL cycle writes memory data, tag, valid, check bits into line, stall=1; then IDLE, load hits; 2 stall cycles total.
REQ-014 Store: write-through and write-allocate in one cycle; memory word and cache line (data, tag, valid, check bits) updated; no stall.
REQ-015 Simultaneous read_en and write_en: store performed; CPU_read_dout = CPU_write_din; no stall.
REQ-016 Port B: mem_b_dout registered, 1-cycle latency; mem_b_we writes memory; user write whose address hits a valid line SHALL invalidate that line.
REQ-017 Same-address same-cycle writes on both ports: CPU (port A) value wins.
REQ-018 error_dwe writes error_din to data array at error_addr (check bits kept); error_pwe writes error_pin to check-bit array; these take priority over fill/store to same index.
REQ-019 cache_parity_dout = check-bit array[error_addr], combinational.
REQ-020 No requests while idle: CPU_read_dout SHALL hold 0.

Reset
REQ-021 rst low: all valid bits cleared, FSM to IDLE, isCacheStall=0, mem_b_dout=0; memory and data arrays not cleared.
REQ-022 Reset during FILL abandons the fill; line stays invalid.

Configuration
REQ-023 Macro SIMPLE_CACHE_ECC_EN defined: SECDED (Hamming 38,32 + overall parity); check bits 0-5 at code positions 1,2,4,8,16,32, data in remaining positions ascending, bit 6 = even parity over all.
REQ-024 With ECC_EN: single-bit error on hit corrected on CPU_read_dout and line rewritten corrected that cycle; double-bit error treated as miss (refetch).
REQ-025 Without ECC_EN: no checking, parity_bits and cache_parity_dout tied 0, error_pwe ignored.

Structure
REQ-026 Shared package: address field widths, line count 512, memory depth 8192, FSM state enum {IDLE, FILL}.
REQ-027 One sub-module secded_codec (encode, syndrome, correct, double-error flag), instantiated only under ECC_EN.

Verification
REQ-028 Store 0xDEADBEEF @0x40, load 0x40 -> hit, data 0xDEADBEEF, zero stall.
REQ-029 Port B write 0x12345678 @word 0x100, load 0x400 -> 2 stall cycles, then 0x12345678; reload hits.
REQ-030 ECC_EN: cached line 0x0000000F, error_dwe inject 0x0000000E -> load returns 0x0000000F, no stall, line scrubbed.
REQ-031 ECC_EN: inject two-bit flip -> load stalls 2 cycles, returns memory value.
REQ-032 Cached @0x40, port B write 0x1 @word 0x10 -> line invalidated; next load misses, returns 0x1.
REQ-033 Assert rst low mid-FILL -> stall drops immediately, line invalid, next load misses.
